pwm_ramp_ctrl: RTL and testbench

Controller that sequences the duty cycle of a downstream PWM generator. It accepts ramp commands (target duty, step size, step period) over a valid/ready handshake. It then moves the duty output toward the target one step per period, with clamping, and drives the generator's enable. It sits between the register/command interface and the PWM generator, which it feeds through duty_out and pwm_en.

---
 rtl/pwm_pkg.sv | 29 ++
 rtl/pwm_tick_gen.sv | 38 +++
 rtl/pwm_ramp_ctrl.sv | 104 ++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types, default widths and the duty clamping helper for the PWM ramp controller.
package pwm_pkg;

    localparam int PWM_WIDTH   = 8;
    localparam int PWM_PRESC_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        DONE
    } ramp_state_e;

    // Moves cur toward tgt by step, landing exactly on tgt instead of overshooting.
    // Operands are carried in 32 bits so any duty width up to 31 bits has headroom.
    // cur+step is only taken when it stays below tgt, and cur-step only when it stays above tgt,
    // so neither result can wrap.
    function automatic logic [31:0] clamp_step(input logic [31:0] cur,
                                               input logic [31:0] tgt,
                                               input logic [31:0] step);
        logic [31:0] result;
        if (tgt > cur) begin
            result = ((tgt - cur) <= step) ? tgt : (cur + step);
        end else begin
            result = ((cur - tgt) <= step) ? tgt : (cur - step);
        end
        return result;
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Step-period prescaler: counts while enabled and pulses tick when the count reaches the loaded period.
module pwm_tick_gen
    import pwm_pkg::*;
#(
    parameter int PRESC_W = PWM_PRESC_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               load,
    input  logic [PRESC_W-1:0] period,
    input  logic               enable,
    output logic               tick
);

    logic [PRESC_W-1:0] count_q;
    logic [PRESC_W-1:0] period_q;

    assign tick = enable && (count_q == period_q);

    // Latch the period on load and run the counter, wrapping to zero on every tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            period_q <= '0;
        end else begin
            if (load) begin
                period_q <= period;
            end
            if (clear) begin
                count_q <= '0;
            end else if (enable) begin
                count_q <= tick ? '0 : (count_q + 1'b1);
            end
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramp controller: accepts a target/step/period command and walks duty_out toward the target.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int WIDTH   = PWM_WIDTH,
    parameter int PRESC_W = PWM_PRESC_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [WIDTH-1:0]   cmd_target,
    input  logic [WIDTH-1:0]   cmd_step,
    input  logic [PRESC_W-1:0] cmd_period,
    input  logic               abort,
    output logic [WIDTH-1:0]   duty_out,
    output logic               pwm_en,
    output logic               busy,
    output logic               done
);

    ramp_state_e      state_q, state_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic             en_q, en_d;
    logic             accept;
    logic             tick;
    logic [WIDTH-1:0] stepped;

    assign cmd_ready = (state_q == IDLE) && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign duty_out  = duty_q;
    assign pwm_en    = en_q;
    assign stepped   = WIDTH'(clamp_step(32'(duty_q), 32'(target_q), 32'(step_q)));

    pwm_tick_gen #(
        .PRESC_W (PRESC_W)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .load   (accept),
        .period (cmd_period),
        .enable (state_q == RAMP),
        .tick   (tick)
    );

    // Register the FSM state and the duty/enable outputs so the generator sees glitch-free values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            duty_q   <= '0;
            target_q <= '0;
            step_q   <= '0;
            en_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            step_q   <= step_d;
            en_q     <= en_d;
        end
    end

    // Next-state logic: accept commands in IDLE, step on ticks in RAMP, abort returns to IDLE holding duty.
    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        step_d   = step_q;
        en_d     = en_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    target_d = cmd_target;
                    step_d   = (cmd_step == '0) ? WIDTH'(1) : cmd_step;
                    en_d     = 1'b1;
                    state_d  = (cmd_target == duty_q) ? DONE : RAMP;
                end
            end
            RAMP: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tick) begin
                    duty_d = stepped;
                    if (stepped == target_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                en_d    = (target_q != '0);
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: directed vector table, corner sequences, then random traffic vs a model.
module tb_pwm_ramp_ctrl;

    localparam int W  = 8;
    localparam int PW = 16;

    localparam int M_IDLE = 0;
    localparam int M_RAMP = 1;
    localparam int M_DONE = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [W-1:0]  cmd_target = '0;
    logic [W-1:0]  cmd_step = '0;
    logic [PW-1:0] cmd_period = '0;
    logic          abort = 1'b0;
    logic [W-1:0]  duty_out;
    logic          pwm_en;
    logic          busy;
    logic          done;

    int vectors = 0;
    int miscompares = 0;

    int m_mode = M_IDLE;
    int m_duty = 0;
    int m_en = 0;
    int m_tgt = 0;
    int m_step = 1;
    int m_per = 0;
    int m_wait = 0;

    typedef struct {
        logic r;
        logic v;
        int   tgt;
        int   stp;
        int   per;
        logic ab;
        int   e_duty;
        logic e_en;
        logic e_busy;
        logic e_done;
        logic e_ready;
    } vec_t;

    vec_t vec_q[$];

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(
        .WIDTH   (W),
        .PRESC_W (PW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .cmd_step   (cmd_step),
        .cmd_period (cmd_period),
        .abort      (abort),
        .duty_out   (duty_out),
        .pwm_en     (pwm_en),
        .busy       (busy),
        .done       (done)
    );

    function automatic void addVec(input logic r, input logic v, input int tgt, input int stp,
                                   input int per, input logic ab, input int ed, input logic een,
                                   input logic ebusy, input logic edone, input logic eready);
        vec_t x;
        x.r = r; x.v = v; x.tgt = tgt; x.stp = stp; x.per = per; x.ab = ab;
        x.e_duty = ed; x.e_en = een; x.e_busy = ebusy; x.e_done = edone; x.e_ready = eready;
        vec_q.push_back(x);
    endfunction

    // Behavioural reference: a command schedules a duty move every (period+1) edges, clamped at the target.
    task automatic modelStep(input logic r, input logic v, input int tgt, input int stp,
                             input int per, input logic ab);
        if (r) begin
            m_mode = M_IDLE; m_duty = 0; m_en = 0; m_wait = 0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (v) begin
                        m_tgt  = tgt;
                        m_step = (stp == 0) ? 1 : stp;
                        m_per  = per;
                        m_wait = per + 1;
                        m_en   = 1;
                        m_mode = (tgt == m_duty) ? M_DONE : M_RAMP;
                    end
                end
                M_RAMP: begin
                    if (ab) begin
                        m_mode = M_IDLE;
                    end else begin
                        m_wait = m_wait - 1;
                        if (m_wait == 0) begin
                            if (m_tgt > m_duty)
                                m_duty = (m_duty + m_step > m_tgt) ? m_tgt : m_duty + m_step;
                            else
                                m_duty = (m_duty - m_step < m_tgt) ? m_tgt : m_duty - m_step;
                            m_wait = m_per + 1;
                            if (m_duty == m_tgt) m_mode = M_DONE;
                        end
                    end
                end
                default: begin
                    m_en   = (m_tgt != 0) ? 1 : 0;
                    m_mode = M_IDLE;
                end
            endcase
        end
    endtask

    // Drive one cycle of inputs from the falling edge, clock it, and return at the next falling edge.
    task automatic applyStimulus(input logic r, input logic v, input int tgt, input int stp,
                                 input int per, input logic ab);
        reset      = r;
        cmd_valid  = v;
        cmd_target = W'(tgt);
        cmd_step   = W'(stp);
        cmd_period = PW'(per);
        abort      = ab;
        @(posedge clk);
        modelStep(r, v, tgt, stp, per, ab);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int e_duty, input logic e_en,
                               input logic e_busy, input logic e_done, input logic e_ready);
        vectors++;
        if (duty_out !== W'(e_duty) || pwm_en !== e_en || busy !== e_busy ||
            done !== e_done || cmd_ready !== e_ready) begin
            miscompares++;
            $display("[TB] FAIL %s: got duty=%0d en=%b busy=%b done=%b ready=%b, expected duty=%0d en=%b busy=%b done=%b ready=%b",
                     name, duty_out, pwm_en, busy, done, cmd_ready,
                     e_duty, e_en, e_busy, e_done, e_ready);
        end
    endtask

    initial begin
        // r v tgt stp per ab | duty en busy done ready (outputs after the edge)
        addVec(1, 0,   0,   0, 0, 0,   0, 0, 0, 0, 0);
        // ramp up 0 -> 10 by 3
        addVec(0, 1,  10,   3, 0, 0,   0, 1, 1, 0, 0);
        addVec(0, 0,   0,   0, 0, 0,   3, 1, 1, 0, 0);
        addVec(0, 0,   0,   0, 0, 0,   6, 1, 1, 0, 0);
        addVec(0, 0,   0,   0, 0, 0,   9, 1, 1, 0, 0);
        addVec(0, 0,   0,   0, 0, 0,  10, 1, 1, 1, 0);
        addVec(0, 0,   0,   0, 0, 0,  10, 1, 0, 0, 1);
        // jump to 200 in one clamped step
        addVec(0, 1, 200, 255, 0, 0,  10, 1, 1, 0, 0);
        addVec(0, 0,   0,   0, 0, 0, 200, 1, 1, 1, 0);
        addVec(0, 0,   0,   0, 0, 0, 200, 1, 0, 0, 1);
        // ramp down 200 -> 0 by 64 every 3 cycles
        addVec(0, 1,   0,  64, 2, 0, 200, 1, 1, 0, 0);
        addVec(0, 0,   0,   0, 0, 0, 200, 1, 1, 0, 0);
        addVec(0, 0,   0,   0, 0, 0, 200, 1, 1, 0, 0);
        addVec(0, 0,   0,   0, 0, 0, 136, 1, 1, 0, 0);
        addVec(0, 0,   0,   0, 0, 0, 136, 1, 1, 0, 0);
        addVec(0, 0,   0,   0, 0, 0, 136, 1, 1, 0, 0);
        addVec(0, 0,   0,   0, 0, 0,  72, 1, 1, 0, 0);
        addVec(0, 0,   0,   0, 0, 0,  72, 1, 1, 0, 0);
        addVec(0, 0,   0,   0, 0, 0,  72, 1, 1, 0, 0);
        addVec(0, 0,   0,   0, 0, 0,   8, 1, 1, 0, 0);
        addVec(0, 0,   0,   0, 0, 0,   8, 1, 1, 0, 0);
        addVec(0, 0,   0,   0, 0, 0,   8, 1, 1, 0, 0);
        addVec(0, 0,   0,   0, 0, 0,   0, 1, 1, 1, 0);
        addVec(0, 0,   0,   0, 0, 0,   0, 0, 0, 0, 1);
        // go to 50, then a no-op command to 50
        addVec(0, 1,  50,  50, 0, 0,   0, 1, 1, 0, 0);
        addVec(0, 0,   0,   0, 0, 0,  50, 1, 1, 1, 0);
        addVec(0, 0,   0,   0, 0, 0,  50, 1, 0, 0, 1);
        addVec(0, 1,  50,   7, 0, 0,  50, 1, 1, 1, 0);
        addVec(0, 0,   0,   0, 0, 0,  50, 1, 0, 0, 1);
        // step 0 behaves as step 1
        addVec(0, 1,  53,   0, 0, 0,  50, 1, 1, 0, 0);
        addVec(0, 0,   0,   0, 0, 0,  51, 1, 1, 0, 0);
        addVec(0, 0,   0,   0, 0, 0,  52, 1, 1, 0, 0);
        addVec(0, 0,   0,   0, 0, 0,  53, 1, 1, 1, 0);
        addVec(0, 0,   0,   0, 0, 0,  53, 1, 0, 0, 1);
        // upper boundary: 250 -> 255 by 10 must clamp, not wrap
        addVec(0, 1, 250, 255, 0, 0,  53, 1, 1, 0, 0);
        addVec(0, 0,   0,   0, 0, 0, 250, 1, 1, 1, 0);
        addVec(0, 0,   0,   0, 0, 0, 250, 1, 0, 0, 1);
        addVec(0, 1, 255,  10, 0, 0, 250, 1, 1, 0, 0);
        addVec(0, 0,   0,   0, 0, 0, 255, 1, 1, 1, 0);
        addVec(0, 0,   0,   0, 0, 0, 255, 1, 0, 0, 1);

        @(negedge clk);
        foreach (vec_q[i]) begin
            applyStimulus(vec_q[i].r, vec_q[i].v, vec_q[i].tgt, vec_q[i].stp, vec_q[i].per, vec_q[i].ab);
            checkOutput($sformatf("table[%0d]", i), vec_q[i].e_duty, vec_q[i].e_en,
                        vec_q[i].e_busy, vec_q[i].e_done, vec_q[i].e_ready);
        end

        // Reset in the middle of a 255 -> 0 ramp
        applyStimulus(0, 1, 0, 1, 0, 0);
        checkOutput("rst_accept", 255, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rst_ramping", 253, 1, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("rst_mid_ramp", 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("rst_release", 0, 0, 0, 0, 1);

        // Abort after duty reaches 15 on a 0 -> 100 ramp, step 5, period 3
        applyStimulus(0, 1, 100, 5, 3, 0);
        checkOutput("abort_accept", 0, 1, 1, 0, 0);
        for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("abort_pre", 15, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("abort_hold", 15, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("abort_no_done", 15, 1, 0, 0, 1);

        // Abort landing on the same edge as a tick blocks the update
        applyStimulus(0, 1, 100, 5, 0, 0);
        checkOutput("abort_tick_accept", 15, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("abort_on_tick", 15, 1, 0, 0, 1);

        // Abort in IDLE is ignored and the command alongside it is taken
        applyStimulus(0, 1, 20, 5, 0, 1);
        checkOutput("abort_idle_accept", 15, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("abort_idle_done", 20, 1, 1, 1, 0);

        // Random traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            logic r, v, ab;
            int   tgt, stp, per;
            r   = ($urandom_range(0, 63) == 0);
            v   = ($urandom_range(0, 3) == 0);
            ab  = ($urandom_range(0, 29) == 0);
            tgt = $urandom_range(0, 255);
            stp = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
            per = $urandom_range(0, 3);
            applyStimulus(r, v, tgt, stp, per, ab);
            checkOutput($sformatf("random[%0d]", n), m_duty, (m_en != 0), (m_mode != M_IDLE),
                        (m_mode == M_DONE), (m_mode == M_IDLE) && !r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
